// File: rtl/cnna_cnt_pkg.sv
// Shared defaults and slice helper for the cnna nested loop counter.
package cnna_cnt_pkg;
  localparam int C_LEVELS_DEF = 4;
  localparam int C_WIDTH_DEF  = 8;

  // LSB of level lvl inside a packed per-level bus of w-bit fields.
  function automatic int lvl_lsb(input int lvl, input int w);
    return lvl * w;
  endfunction
endpackage

// File: rtl/cm_cnt_lvl.sv
// One nest level: wrap counter whose last flag is derived from the next-state count.
module cm_cnt_lvl #(
  parameter int C_WIDTH = cnna_cnt_pkg::C_WIDTH_DEF
) (
  input  logic               I_clk,
  input  logic               I_rst_n,
  input  logic               I_cnt_en,
  input  logic               I_inc,
  input  logic [C_WIDTH-1:0] I_upper,
  output logic [C_WIDTH-1:0] O_cnt,
  output logic               O_last
);
  logic               small_bnd;
  logic [C_WIDTH-1:0] umax;
  logic [C_WIDTH-1:0] cnt_nxt;
  logic               last_nxt;

  assign small_bnd = (I_upper < C_WIDTH'(2));
  assign umax      = I_upper - C_WIDTH'(1);

  always_comb begin
    cnt_nxt = O_cnt;
    if (!I_cnt_en)  cnt_nxt = '0;
    else if (I_inc) cnt_nxt = O_last ? '0 : O_cnt + C_WIDTH'(1);
    // Bounds 0/1 pin the flag so the level forwards every carry it receives.
    last_nxt = small_bnd | (cnt_nxt == umax);
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_cnt  <= '0;
      O_last <= 1'b0;
    end else if (!I_cnt_en || I_inc) begin
      O_cnt  <= cnt_nxt;
      O_last <= last_nxt;
    end
  end
endmodule

// File: rtl/cm_cnt_nest.sv
// N-level nested loop counter: per-level wrap counters, carry chain and done pulse.
module cm_cnt_nest
  import cnna_cnt_pkg::*;
#(
  parameter int C_LEVELS = C_LEVELS_DEF,
  parameter int C_WIDTH  = C_WIDTH_DEF
) (
  input  logic                        I_clk,
  input  logic                        I_rst_n,
  input  logic                        I_cnt_en,
  input  logic                        I_cnt_valid,
  input  logic [C_LEVELS*C_WIDTH-1:0] I_cnt_upper,
  output logic [C_LEVELS*C_WIDTH-1:0] O_cnt,
  output logic [C_LEVELS-1:0]         O_last,
  output logic [C_LEVELS-1:0]         O_carry,
  output logic                        O_done
);
  logic                adv;
  logic [C_LEVELS-1:0] inc;

  assign adv = I_cnt_en & I_cnt_valid;

  for (genvar g = 0; g < C_LEVELS; g++) begin : g_lvl
    if (g == 0) begin : g_in
      assign inc[g] = adv;
    end else begin : g_in
      assign inc[g] = O_carry[g-1];
    end
    assign O_carry[g] = inc[g] & O_last[g];

    cm_cnt_lvl #(.C_WIDTH(C_WIDTH)) u_lvl (
      .I_clk    (I_clk),
      .I_rst_n  (I_rst_n),
      .I_cnt_en (I_cnt_en),
      .I_inc    (inc[g]),
      .I_upper  (I_cnt_upper[lvl_lsb(g, C_WIDTH) +: C_WIDTH]),
      .O_cnt    (O_cnt[lvl_lsb(g, C_WIDTH) +: C_WIDTH]),
      .O_last   (O_last[g])
    );
  end

  // Carry already includes I_cnt_en, so a clear on the wrap edge suppresses done.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) O_done <= 1'b0;
    else          O_done <= O_carry[C_LEVELS-1];
  end
endmodule

// File: tb/tb_cm_cnt_nest.sv
// Randomized bench for cm_cnt_nest against a linear-index mixed-radix model.
module tb_cm_cnt_nest;
  import cnna_cnt_pkg::*;
  localparam int L = 3;
  localparam int W = 4;

  logic           I_clk = 1'b0;
  logic           I_rst_n = 1'b0;
  logic           I_cnt_en = 1'b0;
  logic           I_cnt_valid = 1'b0;
  logic [L*W-1:0] I_cnt_upper = '0;
  logic [L*W-1:0] O_cnt;
  logic [L-1:0]   O_last;
  logic [L-1:0]   O_carry;
  logic           O_done;

  cm_cnt_nest #(.C_LEVELS(L), .C_WIDTH(W)) dut (
    .I_clk       (I_clk),
    .I_rst_n     (I_rst_n),
    .I_cnt_en    (I_cnt_en),
    .I_cnt_valid (I_cnt_valid),
    .I_cnt_upper (I_cnt_upper),
    .O_cnt       (O_cnt),
    .O_last      (O_last),
    .O_carry     (O_carry),
    .O_done      (O_done)
  );

  always #5 I_clk = ~I_clk;

  int nvec = 0;
  int nerr = 0;
  int u[L];
  int idx = 0;
  bit rst_st = 1'b1;
  bit exp_done = 1'b0;
  int adv_since = 0;
  bit prev_en = 1'b0;
  logic [L*W-1:0] prev_upper = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rad(input int i);
    return (u[i] < 1) ? 1 : u[i];
  endfunction

  function automatic int total();
    int t = 1;
    for (int i = 0; i < L; i++) t *= rad(i);
    return t;
  endfunction

  function automatic int dig(input int i);
    int rem = idx;
    for (int j = 0; j < i; j++) rem /= rad(j);
    return rem % rad(i);
  endfunction

  function automatic logic [31:0] exp_cnt();
    logic [31:0] r = '0;
    for (int i = 0; i < L; i++) r[lvl_lsb(i, W) +: W] = W'(dig(i));
    return r;
  endfunction

  function automatic logic [31:0] exp_last();
    logic [31:0] r = '0;
    for (int i = 0; i < L; i++) r[i] = !rst_st && (dig(i) == rad(i) - 1);
    return r;
  endfunction

  function automatic logic [31:0] exp_carry(input bit en, input bit vl);
    logic [31:0] r = '0;
    bit c = en && vl && !rst_st;
    for (int i = 0; i < L; i++) begin
      c = c && (dig(i) == rad(i) - 1);
      r[i] = c;
    end
    return r;
  endfunction

  task automatic set_upper(input int a, input int b, input int c);
    u[0] = a; u[1] = b; u[2] = c;
    for (int i = 0; i < L; i++) I_cnt_upper[lvl_lsb(i, W) +: W] = W'(u[i]);
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_cnt"}, 32'(O_cnt), exp_cnt());
    chk({tag, "_last"}, 32'(O_last), exp_last());
    chk({tag, "_done"}, 32'(O_done), 32'(exp_done));
  endtask

  // Drive one cycle, check carry before the edge and registered outputs after.
  task automatic cycle(input bit en, input bit vl);
    I_cnt_en = en;
    I_cnt_valid = vl;
    #2;
    chk("carry", 32'(O_carry), exp_carry(en, vl));
    if (en && prev_en) chk("upper_static", 32'(I_cnt_upper), 32'(prev_upper));
    prev_en = en;
    prev_upper = I_cnt_upper;
    @(posedge I_clk);
    #1;
    exp_done = en && vl && !rst_st && (idx == total() - 1);
    if (!en) begin
      idx = 0; rst_st = 1'b0; adv_since = 0;
    end else if (vl && !rst_st) begin
      idx = (idx + 1) % total();
      adv_since++;
    end
    if (exp_done) begin
      chk("adv_per_done", 32'(adv_since), 32'(total()));
      adv_since = 0;
    end
    check_outs("cyc");
  endtask

  initial begin
    set_upper(3, 2, 4);
    #12;
    check_outs("reset");
    @(posedge I_clk); #1;
    I_rst_n = 1'b1;

    // Basic nest: 24 tuples, one done, back to zero.
    cycle(1'b0, 1'b0);
    for (int k = 0; k < 26; k++) cycle(1'b1, 1'b1);

    // Degenerate bounds 1 and 0 with a bound-2 outer level.
    set_upper(1, 0, 2);
    cycle(1'b0, 1'b0);
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'b1);

    // Bound 2 straight from clear.
    set_upper(2, 1, 1);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1);

    // Stalls with 12 advances per done.
    set_upper(4, 3, 1);
    cycle(1'b0, 1'b0);
    for (int k = 0; k < 80; k++) cycle(1'b1, 1'($urandom_range(0, 1)));

    // Clear lands on the wrap edge.
    set_upper(2, 2, 1);
    cycle(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);

    // Asynchronous reset at tuple (2,1).
    set_upper(3, 2, 1);
    cycle(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1);
    chk("pre_rst_cnt", 32'(O_cnt), 32'h012);
    I_cnt_en = 1'b0;
    I_cnt_valid = 1'b0;
    #2;
    I_rst_n = 1'b0;
    #1;
    rst_st = 1'b1; idx = 0; exp_done = 1'b0; adv_since = 0; prev_en = 1'b0;
    check_outs("async_rst");
    @(posedge I_clk); #1;
    I_rst_n = 1'b1;
    cycle(1'b0, 1'b0);
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'b1);

    // Random bounds, enables and strobes.
    for (int r = 0; r < 8; r++) begin
      set_upper($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
      cycle(1'b0, 1'b0);
      for (int k = 0; k < 50; k++)
        cycle(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
